// File: rtl/alu_sequencer_if.sv
// Request / ALU / response signal bundle for alu_sequencer.
// master: requester, ALU and response consumer; slave: the sequencer.
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_chain;

    logic [7:0] alu_a_out;
    logic [7:0] alu_b_out;
    logic [1:0] alu_op_out;
    logic [7:0] alu_result_in;
    logic       alu_carry_in;
    logic       alu_zero_in;
    logic       alu_negative_in;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, req_chain,
        input  req_ready,
        input  alu_a_out, alu_b_out, alu_op_out,
        output alu_result_in, alu_carry_in, alu_zero_in, alu_negative_in,
        input  rsp_valid, rsp_result, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_chain,
        output req_ready,
        output alu_a_out, alu_b_out, alu_op_out,
        input  alu_result_in, alu_carry_in, alu_zero_in, alu_negative_in,
        output rsp_valid, rsp_result, rsp_flags,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one op at a time through an external pipelined ALU and returns result + {N,C,Z}.
// Define ALU_SEQ_CHAIN_EN to let req_chain substitute the previous result for operand A.
module alu_sequencer (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus,
    output logic           busy
);

    typedef enum logic [2:0] {IDLE, EXEC, RES, FLAG, RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;

    state_t     state_q;
    state_t     state_d;
    logic       req_ready_c;
    logic       rsp_valid_c;
    logic       busy_c;
    logic       accept;
    logic       capture;
    logic [7:0] a_sel;
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [1:0] alu_op_q;
    logic [7:0] rsp_result_q;
    logic [2:0] rsp_flags_q;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign capture = (state_q == FLAG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = EXEC;
            EXEC:    state_d = RES;
            RES:     state_d = FLAG;
            FLAG:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                busy_c      = 1'b0;
            end
            RESP:    rsp_valid_c = 1'b1;
            default: ;
        endcase
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Last captured result; loads on every FLAG->RESP edge, handshake or not.
    logic [7:0] chain_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
        end else if (capture) begin
            chain_q <= bus.alu_result_in;
        end
    end

    assign a_sel = bus.req_chain ? chain_q : bus.req_a;
`else
    logic unused_req_chain;

    assign unused_req_chain = bus.req_chain;
    assign a_sel            = bus.req_a;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            if (accept) begin
                alu_a_q  <= a_sel;
                alu_b_q  <= bus.req_b;
                alu_op_q <= bus.req_op;
            end
            if (capture) begin
                rsp_result_q <= bus.alu_result_in;
                rsp_flags_q  <= {bus.alu_negative_in, bus.alu_carry_in, bus.alu_zero_in};
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign busy           = busy_c;
    assign bus.alu_a_out  = alu_a_q;
    assign bus.alu_b_out  = alu_b_q;
    assign bus.alu_op_out = alu_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: pipelined ALU stand-in, directed cases, random ops.
// Expectations follow ALU_SEQ_CHAIN_EN when it is defined.
module tb_alu_sequencer;

    logic clk;
    logic reset;
    logic busy;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: result/carry one clock after operands, zero/negative one clock later.
    logic [8:0] alu_wide;
    always_comb begin
        case (bus.alu_op_out)
            2'd0:    alu_wide = {1'b0, bus.alu_a_out} + {1'b0, bus.alu_b_out};
            2'd1:    alu_wide = {1'b0, bus.alu_a_out} - {1'b0, bus.alu_b_out};
            2'd2:    alu_wide = {1'b0, bus.alu_a_out & bus.alu_b_out};
            default: alu_wide = {1'b0, bus.alu_a_out | bus.alu_b_out};
        endcase
    end

    always @(posedge clk) begin
        bus.alu_result_in   <= alu_wide[7:0];
        bus.alu_carry_in    <= alu_wide[8];
        bus.alu_zero_in     <= (bus.alu_result_in == 8'h00);
        bus.alu_negative_in <= bus.alu_result_in[7];
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] chain_ref;
    logic [1:0] exp_op;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_res;
    logic [2:0] exp_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; carry is ADD overflow or SUB borrow, {N,C,Z}.
    function automatic logic [10:0] ref_alu(input int op, input int a, input int b);
        int r;
        bit c;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b);   end
            2: r = a & b;
            default: r = a | b;
        endcase
        r = r & 255;
        return {(r >= 128), c, (r == 0), 8'(r)};
    endfunction

    task automatic set_expected(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic ch);
        exp_op = op;
        exp_b  = b;
`ifdef ALU_SEQ_CHAIN_EN
        exp_a  = ch ? chain_ref : a;
`else
        exp_a  = a;
        if (ch) exp_a = a;
`endif
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ch);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_chain = ch;
        chk("req_ready_idle", bus.req_ready, 1);
        set_expected(op, a, b, ch);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("busy_exec", busy, 1);
        chk("alu_operands", {bus.alu_op_out, bus.alu_a_out, bus.alu_b_out}, {exp_op, exp_a, exp_b});
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            chk("alu_hold", {bus.alu_op_out, bus.alu_a_out, bus.alu_b_out}, {exp_op, exp_a, exp_b});
        end
        chk("rsp_latency", n, 3);
        {exp_flags, exp_res} = ref_alu(int'(exp_op), int'(exp_a), int'(exp_b));
        chain_ref = exp_res;
        chk("rsp_result", bus.rsp_result, exp_res);
        chk("rsp_flags", bus.rsp_flags, exp_flags);
    endtask

    task automatic hold(input int k);
        repeat (k) begin
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_result", {bus.rsp_flags, bus.rsp_result}, {exp_flags, exp_res});
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_busy", busy, 1);
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_hs_valid", bus.rsp_valid, 0);
        chk("post_hs_req_ready", bus.req_ready, 1);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_retain", {bus.rsp_flags, bus.rsp_result}, {exp_flags, exp_res});
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ch, input int k);
        send(op, a, b, ch);
        wait_rsp();
        hold(k);
        finish_rsp();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_rsp"}, {bus.rsp_flags, bus.rsp_result}, 11'h000);
        chk({tag, "_alu"}, {bus.alu_op_out, bus.alu_a_out, bus.alu_b_out}, 18'h00000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bit seen;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.req_chain = 1'b0;
        bus.rsp_ready = 1'b0;
        chain_ref     = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b1;

        run(2'd0, 8'hF0, 8'h20, 1'b0, 0);
        chk("add_f0_20", {bus.rsp_flags, bus.rsp_result}, {3'b010, 8'h10});
        run(2'd1, 8'h03, 8'h05, 1'b0, 1);
        chk("sub_03_05", {bus.rsp_flags, bus.rsp_result}, {3'b110, 8'hFE});
        run(2'd1, 8'h05, 8'h05, 1'b0, 0);
        chk("sub_05_05", {bus.rsp_flags, bus.rsp_result}, {3'b001, 8'h00});
        run(2'd2, 8'hAA, 8'h55, 1'b0, 2);
        chk("and_aa_55", {bus.rsp_flags, bus.rsp_result}, {3'b001, 8'h00});
        run(2'd3, 8'h80, 8'h01, 1'b0, 0);
        chk("or_80_01", {bus.rsp_flags, bus.rsp_result}, {3'b100, 8'h81});

        // Backpressure with a second request held valid the whole time.
        send(2'd0, 8'h12, 8'h34, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd3;
        bus.req_a     = 8'h0F;
        bus.req_b     = 8'hF0;
        bus.req_chain = 1'b0;
        wait_rsp();
        hold(10);
        finish_rsp();
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        set_expected(2'd3, 8'h0F, 8'hF0, 1'b0);
        chk("second_accept_busy", busy, 1);
        chk("second_accept_alu", {bus.alu_op_out, bus.alu_a_out, bus.alu_b_out}, {exp_op, exp_a, exp_b});
        wait_rsp();
        finish_rsp();
        chk("or_0f_f0", {bus.rsp_flags, bus.rsp_result}, {3'b100, 8'hFF});

        // Reset while in RES aborts the op.
        send(2'd1, 8'h09, 8'h04, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_values("abort");
        chain_ref = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        chk("no_rsp_after_abort", seen, 0);
        chk_reset_values("after_abort");

        run(2'd0, 8'h10, 8'h01, 1'b0, 0);
        chk("chain_first", bus.rsp_result, 8'h11);
        run(2'd0, 8'h30, 8'h01, 1'b1, 0);
`ifdef ALU_SEQ_CHAIN_EN
        chk("chain_second", bus.rsp_result, 8'h12);
`else
        chk("chain_second", bus.rsp_result, 8'h31);
`endif

        for (int i = 0; i < 40; i++) begin
            run(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
